// File: rtl/hex_emitter.sv
// Serial uppercase ASCII-hex formatter: takes one L-byte word, emits optional '*',
// 2L hex digits MSB nibble first, then optional CR LF, one character per transfer.
module hex_emitter #(
  parameter int unsigned L      = 2,
  parameter int unsigned PREFIX = 0,
  parameter int unsigned CRLF   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*L-1:0] num,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_char,
  output logic           out_last
);

  localparam int unsigned W       = 8 * L;
  localparam int unsigned N       = 2 * L + PREFIX + 2 * CRLF;
  localparam int unsigned IDX_W   = $clog2(N + 1);
  localparam int unsigned DIG_END = PREFIX + 2 * L;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [W-1:0]     r_shift;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [7:0]       r_out_char;
  logic             r_out_last;

  logic [1:0]       w_nxt_state;
  logic [W-1:0]     w_nxt_shift;
  logic [IDX_W-1:0] w_nxt_idx;
  logic             w_nxt_in_ready;
  logic             w_nxt_out_valid;
  logic [7:0]       w_nxt_out_char;
  logic             w_nxt_out_last;

  logic [W-1:0]     w_adv_shift;
  logic [IDX_W-1:0] w_adv_idx;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  function automatic logic is_digit(input logic [IDX_W-1:0] pos);
    is_digit = !((PREFIX != 0) && (pos == '0)) && (pos < IDX_W'(DIG_END));
  endfunction

  // Character at sequence position pos; nib is the current top nibble of the word.
  function automatic logic [7:0] enc_char(input logic [IDX_W-1:0] pos,
                                          input logic [3:0]       nib);
    if ((PREFIX != 0) && (pos == '0))
      enc_char = 8'h2A;
    else if (pos < IDX_W'(DIG_END))
      enc_char = hex_ascii(nib);
    else if (pos == IDX_W'(DIG_END))
      enc_char = 8'h0D;
    else
      enc_char = 8'h0A;
  endfunction

  // The word shifts left one nibble each time a digit leaves.
  assign w_adv_shift = is_digit(r_idx) ? (r_shift << 4) : r_shift;
  assign w_adv_idx   = r_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_char  <= 8'h00;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_shift     <= w_nxt_shift;
      r_idx       <= w_nxt_idx;
      r_in_ready  <= w_nxt_in_ready;
      r_out_valid <= w_nxt_out_valid;
      r_out_char  <= w_nxt_out_char;
      r_out_last  <= w_nxt_out_last;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_shift     = r_shift;
    w_nxt_idx       = r_idx;
    w_nxt_in_ready  = r_in_ready;
    w_nxt_out_valid = r_out_valid;
    w_nxt_out_char  = r_out_char;
    w_nxt_out_last  = r_out_last;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_nxt_state     = S_SEND;
          w_nxt_shift     = num;
          w_nxt_idx       = '0;
          w_nxt_in_ready  = 1'b0;
          w_nxt_out_valid = 1'b1;
          w_nxt_out_char  = enc_char('0, num[W-1 -: 4]);
          w_nxt_out_last  = 1'b0;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (r_out_last) begin
            w_nxt_state     = S_DONE;
            w_nxt_out_valid = 1'b0;
            w_nxt_out_char  = 8'h00;
            w_nxt_out_last  = 1'b0;
          end else begin
            w_nxt_shift    = w_adv_shift;
            w_nxt_idx      = w_adv_idx;
            w_nxt_out_char = enc_char(w_adv_idx, w_adv_shift[W-1 -: 4]);
            w_nxt_out_last = (w_adv_idx == IDX_W'(N - 1));
          end
        end
      end
      S_DONE: begin
        w_nxt_state    = S_IDLE;
        w_nxt_idx      = '0;
        w_nxt_in_ready = 1'b1;
      end
      default: begin
        w_nxt_state     = S_IDLE;
        w_nxt_idx       = '0;
        w_nxt_in_ready  = 1'b1;
        w_nxt_out_valid = 1'b0;
        w_nxt_out_char  = 8'h00;
        w_nxt_out_last  = 1'b0;
      end
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_hex_emitter.sv
// Directed bench for hex_emitter: a bare 16-bit instance and an L=1 '*HH\r\n' instance.
module tb_hex_emitter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [15:0] a_num;
  logic [7:0]  a_out_char;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_num;
  logic [7:0]  b_out_char;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hex_emitter #(.L(2), .PREFIX(0), .CRLF(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .num(a_num),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_char(a_out_char), .out_last(a_out_last)
  );

  hex_emitter #(.L(1), .PREFIX(1), .CRLF(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .num(b_num),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_char(b_out_char), .out_last(b_out_last)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept n, switch num to n_after right after acceptance, drain at full rate.
  task automatic word_full_rate(input logic [15:0] n, input string s,
                                input logic [15:0] n_after, input logic hold_valid);
    a_in_valid  = 1'b1;
    a_num       = n;
    a_out_ready = 1'b1;
    tick();
    a_num      = n_after;
    a_in_valid = hold_valid;
    for (int i = 0; i < 4; i++) begin
      check({s, " valid"}, 16'(a_out_valid), 16'd1);
      check({s, " in_ready busy"}, 16'(a_in_ready), 16'd0);
      check({s, " char"}, 16'(a_out_char), 16'(s[i]));
      check({s, " last"}, 16'(a_out_last), (i == 3) ? 16'd1 : 16'd0);
      tick();
    end
    check({s, " done valid"}, 16'(a_out_valid), 16'd0);
    check({s, " done in_ready"}, 16'(a_in_ready), 16'd0);
    tick();
    check({s, " idle in_ready"}, 16'(a_in_ready), 16'd1);
    check({s, " idle valid"}, 16'(a_out_valid), 16'd0);
  endtask

  logic [7:0] exp_b [5];
  string      s3;
  int         idx;
  int         cyc;
  logic       pat;

  initial begin
    exp_b = '{8'h2A, 8'h35, 8'h41, 8'h0D, 8'h0A};
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_num = 16'h0000; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_num = 8'h00;    b_out_ready = 1'b1;
    tick();
    tick();
    check("reset in_ready", 16'(a_in_ready), 16'd1);
    check("reset out_valid", 16'(a_out_valid), 16'd0);
    check("reset out_char", 16'(a_out_char), 16'h00);
    check("reset out_last", 16'(a_out_last), 16'd0);
    rst_n = 1'b1;
    tick();

    // Single word at full rate
    word_full_rate(16'h7F7C, "7F7C", 16'h7F7C, 1'b0);

    // Back-to-back with in_valid held: next num already offered while busy
    word_full_rate(16'h7070, "7070", 16'hFFFF, 1'b1);
    word_full_rate(16'hFFFF, "FFFF", 16'h0000, 1'b1);
    word_full_rate(16'h0000, "0000", 16'h0000, 1'b0);

    // Backpressure: out_ready pattern 1,0,0,1,0,1,0,1...
    s3 = "6A9C";
    a_in_valid = 1'b1;
    a_num      = 16'h6A9C;
    tick();
    a_in_valid = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      pat = (cyc == 0) || (cyc >= 3 && (cyc % 2) == 1);
      a_out_ready = pat;
      check("bp valid", 16'(a_out_valid), 16'd1);
      check("bp char", 16'(a_out_char), 16'(s3[idx]));
      check("bp last", 16'(a_out_last), (idx == 3) ? 16'd1 : 16'd0);
      tick();
      if (pat) idx++;
      cyc++;
    end
    check("bp all chars transferred", 16'(idx), 16'd4);
    a_out_ready = 1'b1;
    check("bp done valid", 16'(a_out_valid), 16'd0);
    tick();
    check("bp idle in_ready", 16'(a_in_ready), 16'd1);

    // Prefix + CRLF, L=1
    b_in_valid = 1'b1;
    b_num      = 8'h5A;
    tick();
    b_in_valid = 1'b0;
    b_num      = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("pfx valid", 16'(b_out_valid), 16'd1);
      check("pfx char", 16'(b_out_char), 16'(exp_b[i]));
      check("pfx last", 16'(b_out_last), (i == 4) ? 16'd1 : 16'd0);
      tick();
    end
    check("pfx done valid", 16'(b_out_valid), 16'd0);
    check("pfx done in_ready", 16'(b_in_ready), 16'd0);
    tick();
    check("pfx idle in_ready", 16'(b_in_ready), 16'd1);

    // Reset mid-word, with a transfer pending on the same edge
    a_in_valid = 1'b1;
    a_num      = 16'h1234;
    tick();
    a_in_valid = 1'b0;
    check("rst char1", 16'(a_out_char), 16'h31);
    tick();
    check("rst char2", 16'(a_out_char), 16'h32);
    rst_n = 1'b0;
    tick();
    check("rst out_valid", 16'(a_out_valid), 16'd0);
    check("rst in_ready", 16'(a_in_ready), 16'd1);
    check("rst out_char", 16'(a_out_char), 16'h00);
    check("rst out_last", 16'(a_out_last), 16'd0);
    rst_n = 1'b1;
    tick();
    check("post rst no char", 16'(a_out_valid), 16'd0);
    word_full_rate(16'hABCD, "ABCD", 16'hABCD, 1'b0);

    // num changed after acceptance must not leak into the output
    word_full_rate(16'hBEEF, "BEEF", 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
